// File: rtl/rmw_cnt_pkg.sv
// rtl/rmw_cnt_pkg.sv - shared types and saturating adder for the RMW counter table
package rmw_cnt_pkg;

    localparam int RMW_CNT_W  = 72;
    localparam int RMW_DEPTH  = 128;
    localparam int RMW_ADDR_W = $clog2(RMW_DEPTH);
    localparam int RMW_INC_W  = 16;

    typedef struct packed {
        logic                  valid;
        logic                  is_q;
        logic [RMW_ADDR_W-1:0] addr;
        logic [RMW_INC_W-1:0]  inc;
    } slot_t;

    typedef struct packed {
        logic                  valid;
        logic [RMW_ADDR_W-1:0] addr;
        logic [RMW_CNT_W-1:0]  data;
    } hist_t;

    function automatic logic [RMW_CNT_W-1:0] sat_add(
        input logic [RMW_CNT_W-1:0] base,
        input logic [RMW_INC_W-1:0] inc,
        input logic                 saturate
    );
        logic [RMW_CNT_W:0]   sum;
        logic [RMW_CNT_W-1:0] res;
        sum = {1'b0, base} + {{(RMW_CNT_W + 1 - RMW_INC_W){1'b0}}, inc};
        res = sum[RMW_CNT_W-1:0];
        if (saturate && sum[RMW_CNT_W]) begin
            res = '1;
        end
        return res;
    endfunction

endpackage

// File: rtl/rmw_fwd_hist.sv
// rtl/rmw_fwd_hist.sv - recent-write history with newest-first address match
module rmw_fwd_hist
    import rmw_cnt_pkg::*;
#(
    parameter int CNT_W  = RMW_CNT_W,
    parameter int ADDR_W = RMW_ADDR_W,
    parameter int HIST_D = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_valid,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [CNT_W-1:0]  push_data,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit,
    output logic [CNT_W-1:0]  hit_data
);

    hist_t hist [HIST_D];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < HIST_D; i++) begin
                hist[i] <= '0;
            end
        end else begin
            hist[0].valid <= push_valid;
            hist[0].addr  <= push_addr;
            hist[0].data  <= push_data;
            for (int i = 1; i < HIST_D; i++) begin
                hist[i] <= hist[i-1];
            end
        end
    end

    // Scan oldest to newest so the most recent matching write overrides older ones.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int i = HIST_D - 1; i >= 0; i--) begin
            if (hist[i].valid && (hist[i].addr == lookup_addr)) begin
                hit      = 1'b1;
                hit_data = hist[i].data;
            end
        end
    end

endmodule

// File: rtl/sdpram_rmw_counter.sv
// rtl/sdpram_rmw_counter.sv - full-throughput read-modify-write counter table over an SDPRAM
module sdpram_rmw_counter
    import rmw_cnt_pkg::*;
#(
    parameter int CNT_W    = RMW_CNT_W,
    parameter int DEPTH    = RMW_DEPTH,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int INC_W    = RMW_INC_W,
    parameter int RD_LAT   = 2,
    parameter bit SATURATE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              initial_done,
    input  logic              inc_valid,
    output logic              inc_ready,
    input  logic [ADDR_W-1:0] inc_addr,
    input  logic [INC_W-1:0]  inc_val,
    input  logic              q_valid,
    input  logic [ADDR_W-1:0] q_addr,
    output logic              q_rsp_valid,
    output logic [CNT_W-1:0]  q_rsp_data,
    output logic [ADDR_W-1:0] ram_addrb,
    input  logic [CNT_W-1:0]  ram_doutb,
    output logic              ram_wea,
    output logic [ADDR_W-1:0] ram_addra,
    output logic [CNT_W-1:0]  ram_dina
);

    logic             inc_in_range;
    logic             q_issue;
    slot_t            slot_in;
    slot_t            pipe [RD_LAT];
    slot_t            comp;
    logic             wr_valid;
    logic             fwd_hit;
    logic [CNT_W-1:0] fwd_data;
    logic [CNT_W-1:0] base;
    logic [CNT_W-1:0] sum;

    if (DEPTH == (1 << ADDR_W)) begin : g_full_range
        assign inc_in_range = 1'b1;
    end else begin : g_part_range
        assign inc_in_range = (inc_addr < ADDR_W'(DEPTH));
    end

    assign inc_ready = initial_done & ~q_valid;
    assign q_issue   = q_valid & initial_done;

    always_comb begin
        slot_in = '0;
        if (q_issue) begin
            slot_in.valid = 1'b1;
            slot_in.is_q  = 1'b1;
            slot_in.addr  = q_addr;
        end else begin
            slot_in.valid = inc_valid & inc_ready & inc_in_range;
            slot_in.addr  = inc_addr;
            slot_in.inc   = inc_val;
        end
    end

    assign ram_addrb = rst ? '0 : slot_in.addr;

    // Slot record travels alongside the RAM read so it lines up with ram_doutb.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= slot_in;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign comp     = pipe[RD_LAT-1];
    assign wr_valid = comp.valid & ~comp.is_q;

    // RD_LAT completions race the RAM read, plus one for the registered write stage.
    rmw_fwd_hist #(
        .CNT_W  (CNT_W),
        .ADDR_W (ADDR_W),
        .HIST_D (RD_LAT + 1)
    ) u_hist (
        .clk         (clk),
        .rst         (rst),
        .push_valid  (wr_valid),
        .push_addr   (comp.addr),
        .push_data   (sum),
        .lookup_addr (comp.addr),
        .hit         (fwd_hit),
        .hit_data    (fwd_data)
    );

    assign base = fwd_hit ? fwd_data : ram_doutb;
    assign sum  = sat_add(base, comp.inc, SATURATE);

    always_ff @(posedge clk) begin
        if (rst) begin
            ram_wea     <= 1'b0;
            ram_addra   <= '0;
            ram_dina    <= '0;
            q_rsp_valid <= 1'b0;
            q_rsp_data  <= '0;
        end else begin
            ram_wea     <= wr_valid;
            q_rsp_valid <= comp.valid & comp.is_q;
            if (wr_valid) begin
                ram_addra <= comp.addr;
                ram_dina  <= sum;
            end
            if (comp.valid && comp.is_q) begin
                q_rsp_data <= base;
            end
        end
    end

endmodule

// File: tb/tb_sdpram_rmw_counter.sv
// tb/tb_sdpram_rmw_counter.sv - directed bench for the RMW counter table, saturating and wrapping builds
module tb_sdpram_rmw_counter;

    localparam int CNT_W  = 72;
    localparam int DEPTH  = 128;
    localparam int ADDR_W = 7;
    localparam int INC_W  = 16;
    localparam int RD_LAT = 2;
    localparam logic [CNT_W-1:0] ALL1 = '1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              hold_init = 1'b1;
    logic              inc_valid = 1'b1;
    logic [ADDR_W-1:0] inc_addr = 7'd3;
    logic [INC_W-1:0]  inc_val = 16'd1;
    logic              q_valid = 1'b0;
    logic [ADDR_W-1:0] q_addr = '0;
    logic              initial_done;

    logic [1:0]        inc_ready;
    logic [1:0]        q_rsp_valid;
    logic [1:0]        ram_wea;
    logic [CNT_W-1:0]  q_rsp_data [2];
    logic [CNT_W-1:0]  ram_dina [2];
    logic [CNT_W-1:0]  ram_doutb [2];
    logic [ADDR_W-1:0] ram_addrb [2];
    logic [ADDR_W-1:0] ram_addra [2];

    logic [CNT_W-1:0]  mem [2][DEPTH];
    logic [CNT_W-1:0]  rd_pipe [2][RD_LAT];
    logic              clearing = 1'b1;
    int                clr_ptr = 0;
    logic              preload_en = 1'b0;
    logic [ADDR_W-1:0] preload_addr = '0;
    logic [CNT_W-1:0]  preload_data = '0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Instance 0 saturates, instance 1 wraps; both see identical stimulus.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        sdpram_rmw_counter #(
            .CNT_W    (CNT_W),
            .DEPTH    (DEPTH),
            .ADDR_W   (ADDR_W),
            .INC_W    (INC_W),
            .RD_LAT   (RD_LAT),
            .SATURATE (g == 0)
        ) dut (
            .clk          (clk),
            .rst          (rst),
            .initial_done (initial_done),
            .inc_valid    (inc_valid),
            .inc_ready    (inc_ready[g]),
            .inc_addr     (inc_addr),
            .inc_val      (inc_val),
            .q_valid      (q_valid),
            .q_addr       (q_addr),
            .q_rsp_valid  (q_rsp_valid[g]),
            .q_rsp_data   (q_rsp_data[g]),
            .ram_addrb    (ram_addrb[g]),
            .ram_doutb    (ram_doutb[g]),
            .ram_wea      (ram_wea[g]),
            .ram_addra    (ram_addra[g]),
            .ram_dina     (ram_dina[g])
        );
        assign ram_doutb[g] = rd_pipe[g][RD_LAT-1];
    end

    // SDPRAM-with-init model: clears every word after reset, old data on read-during-write.
    always @(posedge clk) begin
        if (rst) begin
            clearing <= 1'b1;
            clr_ptr  <= 0;
        end else if (clearing) begin
            for (int g = 0; g < 2; g++) mem[g][clr_ptr] <= '0;
            if (clr_ptr == DEPTH - 1) clearing <= 1'b0;
            clr_ptr <= clr_ptr + 1;
        end else begin
            for (int g = 0; g < 2; g++) begin
                if (preload_en) mem[g][preload_addr] <= preload_data;
                if (ram_wea[g]) mem[g][ram_addra[g]] <= ram_dina[g];
            end
        end
        for (int g = 0; g < 2; g++) begin
            rd_pipe[g][0] <= mem[g][ram_addrb[g]];
            for (int i = 1; i < RD_LAT; i++) rd_pipe[g][i] <= rd_pipe[g][i-1];
        end
    end

    assign initial_done = ~clearing & ~hold_init;

    typedef struct {
        logic              q_v;
        logic [ADDR_W-1:0] q_a;
        logic              i_v;
        logic [ADDR_W-1:0] i_a;
        logic [INC_W-1:0]  i_d;
        logic              e_rdy;
        logic              e_wea;
        logic [ADDR_W-1:0] e_wa;
        logic [CNT_W-1:0]  e_wd;
        logic              e_rv;
        logic [CNT_W-1:0]  e_rd;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(int qv, int qa, int iv, int ia, int id,
                                int rdy, int we, int wa, int wd, int rv, int rd);
        vec_t v;
        v.q_v   = 1'(qv);
        v.q_a   = ADDR_W'(qa);
        v.i_v   = 1'(iv);
        v.i_a   = ADDR_W'(ia);
        v.i_d   = INC_W'(id);
        v.e_rdy = 1'(rdy);
        v.e_wea = 1'(we);
        v.e_wa  = ADDR_W'(wa);
        v.e_wd  = CNT_W'(wd);
        v.e_rv  = 1'(rv);
        v.e_rd  = CNT_W'(rd);
        return v;
    endfunction

    task automatic check(input string name, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        check(name, CNT_W'(act), CNT_W'(exp));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        inc_valid = 1'b0;
        q_valid   = 1'b0;
        inc_addr  = '0;
        inc_val   = '0;
        q_addr    = '0;
    endtask

    initial begin
        // inc7+1, inc9+2, inc7+1, q7 back-to-back; then q/inc collision on addr 9.
        tbl[0]  = mk(0, 0, 1, 7, 1, 1, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 1, 9, 2, 1, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 1, 7, 1, 1, 0, 0, 0, 0, 0);
        tbl[3]  = mk(1, 7, 0, 0, 0, 0, 1, 7, 1, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0, 0, 1, 1, 9, 2, 0, 0);
        tbl[5]  = mk(0, 0, 0, 0, 0, 1, 1, 7, 2, 0, 0);
        tbl[6]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 2);
        tbl[7]  = mk(1, 9, 1, 9, 5, 0, 0, 0, 0, 0, 0);
        tbl[8]  = mk(0, 0, 1, 9, 5, 1, 0, 0, 0, 0, 0);
        tbl[9]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        tbl[10] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 2);
        tbl[11] = mk(0, 0, 0, 0, 0, 1, 1, 9, 7, 0, 0);
        tbl[12] = mk(1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[13] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        tbl[14] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        tbl[15] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 7);

        // Reset state
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chkb($sformatf("rst inc_ready[%0d]", g), inc_ready[g], 1'b0);
            chkb($sformatf("rst q_rsp_valid[%0d]", g), q_rsp_valid[g], 1'b0);
            chkb($sformatf("rst ram_wea[%0d]", g), ram_wea[g], 1'b0);
            check($sformatf("rst q_rsp_data[%0d]", g), q_rsp_data[g], '0);
            check($sformatf("rst ram_dina[%0d]", g), ram_dina[g], '0);
            check($sformatf("rst ram_addra[%0d]", g), CNT_W'(ram_addra[g]), '0);
            check($sformatf("rst ram_addrb[%0d]", g), CNT_W'(ram_addrb[g]), '0);
        end
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 400 && clearing; i++) next_cycle();
        chkb("ram clear timeout", clearing, 1'b0);

        // Test 1: inc held while initial_done=0, ready rises with initial_done
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chkb($sformatf("t1 hold%0d inc_ready", k), inc_ready[0], 1'b0);
            chkb($sformatf("t1 hold%0d ram_wea", k), ram_wea[0], 1'b0);
            next_cycle();
        end
        hold_init = 1'b0;
        @(negedge clk);
        chkb("t1 inc_ready same cycle", inc_ready[0], 1'b1);
        next_cycle();
        idle_inputs();
        next_cycle();
        next_cycle();
        @(negedge clk);
        chkb("t1 first wea", ram_wea[0], 1'b1);
        check("t1 first addra", CNT_W'(ram_addra[0]), CNT_W'(3));
        check("t1 first dina", ram_dina[0], CNT_W'(1));
        next_cycle();
        @(negedge clk);
        chkb("t1 single wea", ram_wea[0], 1'b0);
        next_cycle();

        // Tests 3 and 5 from the vector table
        for (int k = 0; k < 16; k++) begin
            q_valid   = tbl[k].q_v;
            q_addr    = tbl[k].q_a;
            inc_valid = tbl[k].i_v;
            inc_addr  = tbl[k].i_a;
            inc_val   = tbl[k].i_d;
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                chkb($sformatf("row%0d inc_ready[%0d]", k, g), inc_ready[g], tbl[k].e_rdy);
                chkb($sformatf("row%0d ram_wea[%0d]", k, g), ram_wea[g], tbl[k].e_wea);
                if (tbl[k].e_wea) begin
                    check($sformatf("row%0d ram_addra[%0d]", k, g), CNT_W'(ram_addra[g]), CNT_W'(tbl[k].e_wa));
                    check($sformatf("row%0d ram_dina[%0d]", k, g), ram_dina[g], tbl[k].e_wd);
                end
                chkb($sformatf("row%0d q_rsp_valid[%0d]", k, g), q_rsp_valid[g], tbl[k].e_rv);
                if (tbl[k].e_rv) begin
                    check($sformatf("row%0d q_rsp_data[%0d]", k, g), q_rsp_data[g], tbl[k].e_rd);
                end
            end
            next_cycle();
        end
        idle_inputs();
        repeat (3) next_cycle();

        // Test 2: eight back-to-back +3 on addr 5, then query
        for (int k = 0; k < 8; k++) begin
            inc_valid = 1'b1;
            inc_addr  = 7'd5;
            inc_val   = 16'd3;
            next_cycle();
        end
        idle_inputs();
        q_valid = 1'b1;
        q_addr  = 7'd5;
        next_cycle();
        idle_inputs();
        next_cycle();
        @(negedge clk);
        chkb("t2 rsp not early", q_rsp_valid[0], 1'b0);
        chkb("t2 last wea", ram_wea[0], 1'b1);
        check("t2 last dina", ram_dina[0], CNT_W'(24));
        next_cycle();
        @(negedge clk);
        chkb("t2 rsp valid", q_rsp_valid[0], 1'b1);
        check("t2 rsp data", q_rsp_data[0], CNT_W'(24));
        repeat (4) next_cycle();

        // Test 4: addr 0 preloaded near the top, +10 then query
        preload_en   = 1'b1;
        preload_addr = 7'd0;
        preload_data = ALL1 - CNT_W'(5);
        next_cycle();
        preload_en = 1'b0;
        inc_valid  = 1'b1;
        inc_addr   = 7'd0;
        inc_val    = 16'd10;
        next_cycle();
        idle_inputs();
        q_valid = 1'b1;
        q_addr  = 7'd0;
        next_cycle();
        idle_inputs();
        next_cycle();
        @(negedge clk);
        chkb("t4 sat wea", ram_wea[0], 1'b1);
        check("t4 sat dina", ram_dina[0], ALL1);
        chkb("t4 wrap wea", ram_wea[1], 1'b1);
        check("t4 wrap dina", ram_dina[1], CNT_W'(4));
        next_cycle();
        @(negedge clk);
        chkb("t4 sat rsp valid", q_rsp_valid[0], 1'b1);
        check("t4 sat rsp data", q_rsp_data[0], ALL1);
        chkb("t4 wrap rsp valid", q_rsp_valid[1], 1'b1);
        check("t4 wrap rsp data", q_rsp_data[1], CNT_W'(4));
        repeat (3) next_cycle();
        q_valid = 1'b1;
        q_addr  = 7'd0;
        next_cycle();
        idle_inputs();
        repeat (2) next_cycle();
        @(negedge clk);
        check("t4 sat ram readback", q_rsp_data[0], ALL1);
        check("t4 wrap ram readback", q_rsp_data[1], CNT_W'(4));
        next_cycle();

        // Test 6: reset with three increments in flight
        for (int k = 0; k < 3; k++) begin
            inc_valid = 1'b1;
            inc_addr  = 7'd20;
            inc_val   = 16'd1;
            if (k == 2) rst = 1'b1;
            next_cycle();
        end
        idle_inputs();
        @(negedge clk);
        chkb("t6 wea cleared[0]", ram_wea[0], 1'b0);
        chkb("t6 wea cleared[1]", ram_wea[1], 1'b0);
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 400 && !initial_done; i++) next_cycle();
        chkb("t6 re-init timeout", initial_done, 1'b1);
        for (int i = 0; i < DEPTH + 3; i++) begin
            q_valid = (i < DEPTH);
            q_addr  = ADDR_W'(i);
            @(negedge clk);
            if (i >= 3) begin
                for (int g = 0; g < 2; g++) begin
                    chkb($sformatf("t6 sweep%0d rsp_valid[%0d]", i - 3, g), q_rsp_valid[g], 1'b1);
                    check($sformatf("t6 sweep%0d rsp_data[%0d]", i - 3, g), q_rsp_data[g], '0);
                end
            end
            next_cycle();
        end
        idle_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
